// File: rtl/health_pkg.sv
// Shared definitions for the body-temperature acquisition path.
package health_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        START_CHK,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int unsigned FRAME_DATA_BITS    = 8;
    localparam int unsigned DEFAULT_RESET_TEMP = 37;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous line that idles high.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/temperature_sensor_reader.sv
// Periodically requests a conversion from the one-wire temperature sensor,
// deserializes and checks its reply, and publishes validated readings.
module temperature_sensor_reader
    import health_pkg::*;
#(
    parameter int unsigned BIT_CYCLES    = 16,
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned TIMEOUT_BITS  = 4,
    parameter logic [7:0]  RESET_TEMP    = 8'(DEFAULT_RESET_TEMP)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       sensorData,
    output logic       sensorStart,
    output logic [7:0] temperature,
    output logic       temperatureValid,
    output logic       frameError,
    output logic       timeoutError
);

    localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BITS * BIT_CYCLES;
    localparam int unsigned PW = $clog2(SAMPLE_PERIOD);
    localparam int unsigned BW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IW = $clog2(FRAME_DATA_BITS);

    localparam logic [PW-1:0] PERIOD_LAST  = PW'(SAMPLE_PERIOD - 1);
    localparam logic [BW-1:0] TIMEOUT_LAST = BW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] HALF_LAST    = BW'(BIT_CYCLES / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST     = BW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(FRAME_DATA_BITS - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [PW-1:0]              r_period_cnt;
    logic [BW-1:0]              r_bit_cnt;
    logic [IW-1:0]              r_idx;
    logic [FRAME_DATA_BITS-1:0] r_data;
    logic                       r_par;
    logic [7:0]                 r_temp;
    logic                       r_start;
    logic                       r_valid;
    logic                       r_ferr;
    logic                       r_tout;

    logic w_line;
    logic w_wrap;
    logic w_bit_last;
    logic w_cnt_clr;
    logic w_shift;
    logic w_par_load;
    logic w_start_nxt;
    logic w_valid_nxt;
    logic w_ferr_nxt;
    logic w_tout_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (sensorData),
        .o_q   (w_line)
    );

    assign w_wrap     = enable && (r_period_cnt == PERIOD_LAST);
    assign w_bit_last = (r_bit_cnt == BIT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_par_load  = 1'b0;
        w_start_nxt = 1'b0;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_tout_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_wrap) begin
                    w_state_nxt = WAIT_START;
                    w_start_nxt = 1'b1;
                    w_cnt_clr   = 1'b1;
                end
            end
            WAIT_START: begin
                if (!w_line) begin
                    w_state_nxt = START_CHK;
                    w_cnt_clr   = 1'b1;
                end else if (r_bit_cnt == TIMEOUT_LAST) begin
                    w_state_nxt = IDLE;
                    w_tout_nxt  = 1'b1;
                end
            end
            START_CHK: begin
                if (r_bit_cnt == HALF_LAST) begin
                    w_cnt_clr = 1'b1;
                    if (!w_line) begin
                        w_state_nxt = DATA;
                    end else begin
                        w_state_nxt = IDLE;
                        w_ferr_nxt  = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_bit_last) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = PARITY;
                    end
                end
            end
            PARITY: begin
                if (w_bit_last) begin
                    w_cnt_clr   = 1'b1;
                    w_par_load  = 1'b1;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_bit_last) begin
                    w_state_nxt = IDLE;
                    if (w_line && !(^{r_data, r_par})) begin
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Dropping enable overrides everything: silent abort, no pulses.
        if (!enable) begin
            w_state_nxt = IDLE;
            w_cnt_clr   = 1'b1;
            w_shift     = 1'b0;
            w_par_load  = 1'b0;
            w_start_nxt = 1'b0;
            w_valid_nxt = 1'b0;
            w_ferr_nxt  = 1'b0;
            w_tout_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
            r_bit_cnt    <= '0;
            r_idx        <= '0;
            r_data       <= '0;
            r_par        <= 1'b0;
            r_temp       <= RESET_TEMP;
            r_start      <= 1'b0;
            r_valid      <= 1'b0;
            r_ferr       <= 1'b0;
            r_tout       <= 1'b0;
        end else begin
            if (!enable || w_wrap) begin
                r_period_cnt <= '0;
            end else begin
                r_period_cnt <= r_period_cnt + 1'b1;
            end
            if (w_cnt_clr) begin
                r_bit_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_start_nxt) begin
                r_idx <= '0;
            end else if (w_shift) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_shift) begin
                r_data <= {r_data[FRAME_DATA_BITS-2:0], w_line};
            end
            if (w_par_load) begin
                r_par <= w_line;
            end
            if (w_valid_nxt) begin
                r_temp <= r_data;
            end
            r_start <= w_start_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_tout  <= w_tout_nxt;
        end
    end

    assign sensorStart      = r_start;
    assign temperature      = r_temp;
    assign temperatureValid = r_valid;
    assign frameError       = r_ferr;
    assign timeoutError     = r_tout;

endmodule

// File: tb/tb_temperature_sensor_reader.sv
// Scoreboard bench: a sensor model replies to requests with directed frames.
module tb_temperature_sensor_reader;

    localparam int BITC   = 16;
    localparam int PERIOD = 1000;

    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_TOUT  = 2;

    typedef struct {
        int         kind;
        logic [7:0] temp;
        longint     cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       sensorData;
    logic       sensorStart;
    logic [7:0] temperature;
    logic       temperatureValid;
    logic       frameError;
    logic       timeoutError;

    exp_t   sb[$];
    int     n_checks;
    int     n_fail;
    int     n_starts;
    longint cyc;

    temperature_sensor_reader #(
        .BIT_CYCLES    (16),
        .SAMPLE_PERIOD (1000),
        .TIMEOUT_BITS  (4),
        .RESET_TEMP    (8'd37)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .sensorData       (sensorData),
        .sensorStart      (sensorStart),
        .temperature      (temperature),
        .temperatureValid (temperatureValid),
        .frameError       (frameError),
        .timeoutError     (timeoutError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        int   npulse;
        int   kind;
        exp_t e;
        if (rst_n) begin
            if (sensorStart) n_starts++;
            npulse = int'(temperatureValid) + int'(frameError) + int'(timeoutError);
            if (npulse != 0) begin
                kind = temperatureValid ? K_VALID : (frameError ? K_FERR : K_TOUT);
                if (npulse > 1) begin
                    check("pulse_exclusive", npulse, 1);
                end else if (sb.size() == 0) begin
                    check("unexpected_pulse_kind", kind, -1);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", kind, e.kind);
                    check("pulse_temperature", temperature, e.temp);
                    if (e.cyc != 0) check("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input int kind, input logic [7:0] temp, input longint c);
        exp_t e;
        e.kind = kind;
        e.temp = temp;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic wait_start(output longint at);
        bit seen;
        seen = 1'b0;
        at   = 0;
        for (int i = 0; i < PERIOD + 100 && !seen; i++) begin
            @(negedge clk);
            if (sensorStart) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        if (!seen) check("request_seen", 0, 1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int nbits);
        logic [10:0] f;
        f = {1'b0, d, p, s};
        repeat (10) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sensorData = f[10-i];
            repeat (BITC) @(negedge clk);
        end
        sensorData = 1'b1;
    endtask

    initial begin
        longint t0;
        longint t1;
        n_checks   = 0;
        n_fail     = 0;
        n_starts   = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        sensorData = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_temperature", temperature, 37);
        check("reset_pulses", {sensorStart, temperatureValid, frameError, timeoutError}, 0);
        rst_n = 1'b1;

        repeat (2000) @(negedge clk);
        check("disabled_requests", n_starts, 0);
        check("disabled_temperature", temperature, 37);

        enable = 1'b1;
        wait_start(t0);
        push_exp(K_VALID, 8'd37, 0);
        send_frame(8'h25, 1'b1, 1'b1, 11);
        drain("drain_0x25");

        wait_start(t1);
        check("request_spacing", t1 - t0, PERIOD);
        push_exp(K_VALID, 8'd48, 0);
        send_frame(8'h30, 1'b0, 1'b1, 11);
        drain("drain_0x30");

        wait_start(t0);
        push_exp(K_FERR, 8'd48, 0);
        send_frame(8'h28, 1'b1, 1'b1, 11);
        drain("drain_bad_parity");

        wait_start(t0);
        push_exp(K_TOUT, 8'd48, t0 + 64);
        drain("drain_timeout");

        wait_start(t1);
        check("request_after_timeout", t1 - t0, PERIOD);
        push_exp(K_FERR, 8'd48, 0);
        repeat (5) @(negedge clk);
        sensorData = 1'b0;
        repeat (3) @(negedge clk);
        sensorData = 1'b1;
        drain("drain_glitch");

        wait_start(t0);
        push_exp(K_FERR, 8'd48, 0);
        send_frame(8'h22, 1'b0, 1'b0, 11);
        drain("drain_bad_stop");

        wait_start(t0);
        send_frame(8'h27, 1'b0, 1'b1, 4);
        enable = 1'b0;
        repeat (200) @(negedge clk);
        check("abort_temperature", temperature, 48);
        check("abort_no_pending", sb.size(), 0);

        enable = 1'b1;
        wait_start(t0);
        send_frame(8'h27, 1'b0, 1'b1, 5);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_temperature", temperature, 37);
        check("midframe_reset_pulses", {sensorStart, temperatureValid, frameError, timeoutError}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        wait_start(t0);
        push_exp(K_VALID, 8'd39, 0);
        send_frame(8'h27, 1'b0, 1'b1, 11);
        drain("drain_0x27");
        check("final_temperature", temperature, 39);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
